sd_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the stimulus end of the sequence-detector link.

---
 rtl/sd_pattern_tx_pkg.sv | 15 +
 rtl/sd_pat_shreg.sv | 37 +++
 rtl/sd_pattern_tx.sv | 155 +++++++++++++++
 tb/tb_sd_pattern_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sd_pattern_tx_pkg.sv
// Shared definitions for the sequence-detector pattern transmitter.
package sd_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Width of a counter that indexes w items (at least one bit).
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sd_pat_shreg.sv
// Loadable left-shift register for the pattern; next_bit is the bit after the one
// currently on the line, first_bit restarts the captured pattern.
module sd_pat_shreg #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat,
  output logic             first_bit,
  output logic             next_bit
);

  logic [PAT_W-1:0] cap;
  logic [PAT_W-1:0] sh;

  // The MSB goes out straight from the load, so the shifter holds the remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap <= '0;
      sh  <= '0;
    end else if (load) begin
      cap <= pat;
      sh  <= {pat[PAT_W-2:0], 1'b0};
    end else if (reload) begin
      sh  <= {cap[PAT_W-2:0], 1'b0};
    end else if (shift) begin
      sh  <= {sh[PAT_W-2:0], 1'b0};
    end
  end

  assign first_bit = cap[PAT_W-1];
  assign next_bit  = sh[PAT_W-1];

endmodule

// File: rtl/sd_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, with
// optional repetitions separated by idle zero gaps.
module sd_pattern_tx
  import sd_pattern_tx_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pat,
  input  logic [REP_W-1:0] load_reps,
  input  logic [GAP_W-1:0] load_gap,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = idx_width(PAT_W);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);

  state_t           state;
  logic [BIT_W-1:0] bit_idx;
  logic [REP_W-1:0] reps_left;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             sh_shift;
  logic             sh_reload;
  logic             first_bit;
  logic             next_bit;

  assign load_ready = (state == ST_IDLE);
  assign accept     = load_valid && load_ready;

  sd_pat_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .reload    (sh_reload),
    .shift     (sh_shift),
    .pat       (load_pat),
    .first_bit (first_bit),
    .next_bit  (next_bit)
  );

  // Shifter steering mirrors the FSM branches that put a new bit on dout.
  always_comb begin
    sh_shift  = 1'b0;
    sh_reload = 1'b0;
    if (state == ST_SEND && !abort) begin
      if (bit_idx != LAST_IDX) begin
        sh_shift = 1'b1;
      end else if (reps_left != '0 && gap_len == '0) begin
        sh_reload = 1'b1;
      end else begin
        sh_reload = 1'b0;
      end
    end else if (state == ST_GAP && !abort && gap_cnt == '0) begin
      sh_reload = 1'b1;
    end else begin
      sh_shift = 1'b0;
    end
  end

  // Burst FSM; the output registers describe the cycle after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      reps_left  <= '0;
      gap_len    <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_SEND;
            bit_idx    <= '0;
            reps_left  <= load_reps;
            gap_len    <= load_gap;
            dout       <= load_pat[PAT_W-1];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
          end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        ST_SEND: begin
          if (abort) begin
            state      <= ST_IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (bit_idx != LAST_IDX) begin
            bit_idx    <= bit_idx + BIT_W'(1);
            dout       <= next_bit;
            dout_valid <= 1'b1;
          end else if (reps_left == '0) begin
            state      <= ST_IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else if (gap_len == '0) begin
            bit_idx    <= '0;
            reps_left  <= reps_left - REP_W'(1);
            dout       <= first_bit;
            dout_valid <= 1'b1;
          end else begin
            state      <= ST_GAP;
            reps_left  <= reps_left - REP_W'(1);
            gap_cnt    <= gap_len - GAP_W'(1);
            dout       <= 1'b0;
            dout_valid <= 1'b0;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state      <= ST_IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (gap_cnt == '0) begin
            state      <= ST_SEND;
            bit_idx    <= '0;
            dout       <= first_bit;
            dout_valid <= 1'b1;
          end else begin
            gap_cnt    <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_pattern_tx.sv
// Scoreboard bench for sd_pattern_tx with a behavioural 101 Mealy detector on dout.
module tb_sd_pattern_tx;

  localparam int PAT_W = 3;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] load_pat = '0;
  logic [REP_W-1:0] load_reps = '0;
  logic [GAP_W-1:0] load_gap = '0;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  int total = 0;
  int bad = 0;
  int det_cnt = 0;
  int base = 0;
  logic [1:0] hist = 2'b00;
  // Expected per-cycle {dout, dout_valid, done, busy}.
  logic [3:0] exp_q[$];

  sd_pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_pat   (load_pat),
    .load_reps  (load_reps),
    .load_gap   (load_gap),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle against the queue, idle when nothing is queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0)
        check("trace", {dout, dout_valid, done, busy}, exp_q.pop_front());
      else
        check("idle", {dout, dout_valid, done, busy}, 4'b0000);
      if (hist == 2'b10 && dout) det_cnt++;
      hist = {hist[0], dout};
    end
  end

  task automatic load(input logic [PAT_W-1:0] p, input logic [REP_W-1:0] r,
                      input logic [GAP_W-1:0] g, input int cut);
    int w;
    int n;
    w = 0;
    n = 0;
    while (!load_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("load_ready", {3'b000, load_ready}, 4'b0001);
    load_valid = 1'b1;
    load_pat   = p;
    load_reps  = r;
    load_gap   = g;
    @(posedge clk);
    for (int i = 0; i <= int'(r); i++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        if (cut == 0 || n < cut) exp_q.push_back({p[b], 1'b1, 1'b0, 1'b1});
        n++;
      end
      if (i < int'(r)) begin
        for (int j = 0; j < int'(g); j++) begin
          if (cut == 0 || n < cut) exp_q.push_back(4'b0001);
          n++;
        end
      end
    end
    if (cut == 0) exp_q.push_back(4'b0010);
    #1;
    load_valid = 1'b0;
    load_pat   = ~p;
    load_reps  = '0;
    load_gap   = '0;
  endtask

  task automatic drain(input int limit);
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < limit) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain", {3'b000, exp_q.size() == 0}, 4'b0001);
    exp_q.delete();
  endtask

  task automatic check_det(input int expv);
    check("detections", 4'(det_cnt - base), 4'(expv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_outs", {dout, dout_valid, done, busy}, 4'b0000);
    check("reset_ready", {3'b000, load_ready}, 4'b0001);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_outs", {dout, dout_valid, done, busy}, 4'b0000);
    check("idle_ready", {3'b000, load_ready}, 4'b0001);

    base = det_cnt; load(3'b101, 4'd0, 4'd0, 0); drain(20);  check_det(1);
    base = det_cnt; load(3'b101, 4'd2, 4'd0, 0); drain(30);  check_det(3);
    base = det_cnt; load(3'b101, 4'd1, 4'd2, 0); drain(30);  check_det(2);

    // Abort sampled at the end of cycle 5; reload with abort still high in cycle 6.
    base = det_cnt;
    load(3'b101, 4'd3, 4'd0, 5);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle", {dout, dout_valid, done, busy}, 4'b0000);
    load(3'b101, 4'd0, 4'd0, 0);
    abort = 1'b0;
    drain(20);
    check_det(2);

    // Maximum reps and gap; loads offered mid-burst must be ignored.
    base = det_cnt;
    load(3'b110, 4'd15, 4'd15, 0);
    repeat (3) @(posedge clk);
    #1;
    load_valid = 1'b1; load_pat = 3'b011; load_reps = 4'd7; load_gap = 4'd1;
    repeat (5) @(posedge clk);
    #1 load_valid = 1'b0;
    drain(400);
    check_det(0);

    // Async reset in cycle 20 of a long burst.
    load(3'b110, 4'd15, 4'd15, 0);
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_outs", {dout, dout_valid, done, busy}, 4'b0000);
    check("midrst_ready", {3'b000, load_ready}, 4'b0001);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    base = det_cnt; load(3'b101, 4'd0, 4'd0, 0); drain(20); check_det(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
